// File: rtl/nonce_tx_arbiter_if.sv
// rtl/nonce_tx_arbiter_if.sv - core-side and transmitter-side signal bundle for nonce_tx_arbiter
// Slave modport is the arbiter; master modport is the core array plus word transmitter.
interface nonce_tx_arbiter_if #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
);
    logic [NUM_CORES-1:0]    nonce_valid;
    logic [32*NUM_CORES-1:0] nonce_data;
    logic                    tx_busy;
    logic                    tx_send;
    logic [31:0]             tx_word;
    logic [NUM_CORES-1:0]    pending;
    logic [NUM_CORES-1:0]    overflow;
    logic [IDX_W-1:0]        last_core;

    modport master (
        output nonce_valid, nonce_data, tx_busy,
        input  tx_send, tx_word, pending, overflow, last_core
    );

    modport slave (
        input  nonce_valid, nonce_data, tx_busy,
        output tx_send, tx_word, pending, overflow, last_core
    );
endinterface

// File: rtl/nonce_tx_arbiter.sv
// rtl/nonce_tx_arbiter.sv - round-robin arbiter sharing one 32-bit word transmitter between hashing cores
// Optional NONCE_CORE_TAG_EN: top IDX_W bits of tx_word carry the granted core index.
module nonce_tx_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input logic              clk,
    input logic              reset,
    nonce_tx_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    // Last count value of the busy-rise timeout, i.e. four cycles spent in WAIT_HI.
    localparam logic [1:0]       HI_TIMEOUT = 2'd3;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CORES - 1);

    logic [1:0]           state;
    logic [1:0]           hi_cnt;
    logic [31:0]          held [NUM_CORES];
    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] overflow;
    logic [IDX_W-1:0]     last_core;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     cand;
    logic                 any_win;
    logic                 grant;
    logic                 tx_send;
    logic [31:0]          tx_word;
    logic [31:0]          send_word;

    assign bus.tx_send   = tx_send;
    assign bus.tx_word   = tx_word;
    assign bus.pending   = pending;
    assign bus.overflow  = overflow;
    assign bus.last_core = last_core;

    // Search starts one past the last grant so a core that just sent goes to the back of the line.
    always_comb begin
        any_win = 1'b0;
        winner  = last_core;
        cand    = last_core;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = IDX_W'((int'(last_core) + k) % NUM_CORES);
            if (!any_win && pending[cand]) begin
                any_win = 1'b1;
                winner  = cand;
            end
        end
    end

    assign grant = (state == ST_IDLE) && any_win && !bus.tx_busy;

`ifdef NONCE_CORE_TAG_EN
    assign send_word = {winner, held[winner][31-IDX_W:0]};
`else
    assign send_word = held[winner];
`endif

    // A grant frees the holding slot in the same edge, so a simultaneous new nonce is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            overflow <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                held[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (bus.nonce_valid[i] && (!pending[i] || (grant && winner == IDX_W'(i)))) begin
                    held[i]    <= bus.nonce_data[32*i +: 32];
                    pending[i] <= 1'b1;
                end else begin
                    if (bus.nonce_valid[i]) begin
                        overflow[i] <= 1'b1;
                    end
                    if (grant && winner == IDX_W'(i)) begin
                        pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            hi_cnt    <= '0;
            tx_send   <= 1'b0;
            tx_word   <= '0;
            last_core <= LAST_IDX;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        tx_word   <= send_word;
                        tx_send   <= 1'b1;
                        last_core <= winner;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_send <= 1'b0;
                    hi_cnt  <= '0;
                    state   <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    // A transmitter that never raises busy dropped the word; give up without retry.
                    if (bus.tx_busy) begin
                        state <= ST_WAIT_LO;
                    end else if (hi_cnt == HI_TIMEOUT) begin
                        state <= ST_IDLE;
                    end else begin
                        hi_cnt <= hi_cnt + 2'd1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
